// File: rtl/wb_mem64_resp_if.sv
// rtl/wb_mem64_resp_if.sv - Wishbone 64-bit (lo/hi lane) slave bus bundle
//
// Purpose: groups the Wishbone handshake, address and data signals that pass
// between the ADMA master port and the wb_mem64_resp memory responder.
// Signal suffixes (_i/_o) are from the slave's point of view.
//   wbs_cyc_i/wbs_stb_i/wbs_we_i/wbs_cab_i : cycle, strobe, write, burst hint
//   wbs_adr_i   : byte address, bits [2:0] ignored
//   wbs_sel_i   : byte enables, applied to both lanes
//   wbs_dat_i / wbs_dat64_i : write data lo / hi
//   wbs_dat_o / wbs_dat64_o : read data lo / hi
//   wbs_ack_o / wbs_err_o / wbs_rty_o : terminations
// Modports: master (bus initiator), slave (memory responder).
interface wb_mem64_resp_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic        wbs_cab_i;
  logic [31:0] wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_dat64_i;
  logic [31:0] wbs_dat_o;
  logic [31:0] wbs_dat64_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        wbs_rty_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_adr_i, wbs_sel_i,
           wbs_dat_i, wbs_dat64_i,
    output wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i, wbs_adr_i, wbs_sel_i,
           wbs_dat_i, wbs_dat64_i,
    input  wbs_dat_o, wbs_dat64_o, wbs_ack_o, wbs_err_o, wbs_rty_o
  );
endinterface

// File: rtl/wb_mem64_resp.sv
// rtl/wb_mem64_resp.sv - Wishbone 64-bit slave memory with wait states and backdoor
//
// Purpose: synthesizable 2^AW x 64-bit memory answering Wishbone single beats
// with WAIT programmable wait states, plus a backdoor preload/peek port and a
// per-cycle beat counter.
// Optional feature macro: WB_MEM64_ERR_EN - when defined, addresses with any
// bit above the memory range set terminate with err instead of ack.
// Ports:
//   wb_clk_i   : clock
//   wb_rst_i   : synchronous active-high reset (memory contents kept)
//   wbs        : Wishbone slave bundle (wb_mem64_resp_if.slave)
//   ld_we_i    : backdoor write strobe, writes all 64 bits
//   ld_adr_i   : backdoor word index
//   ld_dat_i   : backdoor write data {hi,lo}
//   ld_dat_o   : backdoor read data, combinational from ld_adr_i
//   beat_cnt_o : terminations counted in the current bus cycle (saturating)
module wb_mem64_resp #(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_mem64_resp_if.slave        wbs,
  input  logic                  ld_we_i,
  input  logic [AW-1:0]         ld_adr_i,
  input  logic [63:0]           ld_dat_i,
  output logic [63:0]           ld_dat_o,
  output logic [15:0]           beat_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_wcnt, w_wcnt_nxt;
  logic [AW-1:0] r_idx;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [63:0]   r_wdat;
  logic          r_err;
  logic [31:0]   r_dat_lo, r_dat_hi;
  logic [15:0]   r_beat;
  logic [63:0]   r_mem [0:(1<<AW)-1];

  logic          w_req;
  logic [AW-1:0] w_adr_idx;
  logic          w_adr_err;
  logic          w_latch;
  logic          w_rd_load;
  logic [AW-1:0] w_rd_idx;
  logic          w_unused;

  assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_adr_idx = wbs.wbs_adr_i[AW+2:3];

`ifdef WB_MEM64_ERR_EN
  assign w_adr_err = |wbs.wbs_adr_i[31:AW+3];
`else
  // Upper address bits alias onto the array.
  assign w_adr_err = 1'b0;
`endif

  assign w_unused = &{1'b0, wbs.wbs_cab_i, wbs.wbs_adr_i[2:0], wbs.wbs_adr_i[31:AW+3]};

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_latch     = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_idx    = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (WAIT == 0) begin
            // Going straight to RESP: read data comes from the live address.
            w_state_nxt = S_RESP;
            w_rd_load   = ~wbs.wbs_we_i & ~w_adr_err;
            w_rd_idx    = w_adr_idx;
          end else begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = 4'(WAIT - 1);
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          // Master withdrew: abort silently, nothing committed.
          w_state_nxt = S_IDLE;
          w_wcnt_nxt  = 4'd0;
        end else if (r_wcnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_rd_load   = ~r_we & ~r_err;
        end else begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end
      end
      S_RESP: begin
        // Termination is already committed; cyc/stb are not re-checked.
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_wcnt   <= 4'd0;
      r_idx    <= '0;
      r_we     <= 1'b0;
      r_sel    <= 4'd0;
      r_wdat   <= 64'd0;
      r_err    <= 1'b0;
      r_dat_lo <= 32'd0;
      r_dat_hi <= 32'd0;
      r_beat   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_latch) begin
        r_idx  <= w_adr_idx;
        r_we   <= wbs.wbs_we_i;
        r_sel  <= wbs.wbs_sel_i;
        r_wdat <= {wbs.wbs_dat64_i, wbs.wbs_dat_i};
        r_err  <= w_adr_err;
      end
      if (w_rd_load) begin
        r_dat_lo <= r_mem[w_rd_idx][31:0];
        r_dat_hi <= r_mem[w_rd_idx][63:32];
      end
      if (!wbs.wbs_cyc_i) begin
        r_beat <= 16'd0;
      end else if (r_state == S_RESP && r_beat != 16'hFFFF) begin
        r_beat <= r_beat + 16'd1;
      end
    end
  end

  // Bus write commits on the edge leaving RESP; the backdoor write is issued
  // afterwards in the same block so it overrides a same-index collision.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && r_state == S_RESP && r_we && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (r_sel[b]) begin
          r_mem[r_idx][8*b +: 8]      <= r_wdat[8*b +: 8];
          r_mem[r_idx][32+8*b +: 8]   <= r_wdat[32+8*b +: 8];
        end
      end
    end
    if (ld_we_i) begin
      r_mem[ld_adr_i] <= ld_dat_i;
    end
  end

  assign ld_dat_o        = r_mem[ld_adr_i];
  assign beat_cnt_o      = r_beat;
  assign wbs.wbs_dat_o   = r_dat_lo;
  assign wbs.wbs_dat64_o = r_dat_hi;
  assign wbs.wbs_ack_o   = (r_state == S_RESP) & ~r_err;
  assign wbs.wbs_err_o   = (r_state == S_RESP) & r_err;
  assign wbs.wbs_rty_o   = 1'b0;

endmodule

// File: tb/tb_wb_mem64_resp.sv
// tb/tb_wb_mem64_resp.sv - directed self-checking bench for wb_mem64_resp
//
// Purpose: drives two responders (WAIT=0 and WAIT=3) through their
// interfaces and checks latency, data, byte enables, aborts, backdoor
// collisions, beat counting and the optional error response.
module tb_wb_mem64_resp;
  logic clk;
  logic rst;

  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic        cab [2];
  logic [31:0] adr [2];
  logic [3:0]  sel [2];
  logic [31:0] dlo [2];
  logic [31:0] dhi [2];
  logic        ld_we  [2];
  logic [9:0]  ld_adr [2];
  logic [63:0] ld_di  [2];

  wire  [31:0] rlo [2];
  wire  [31:0] rhi [2];
  wire         ack [2];
  wire         err [2];
  wire         rty [2];
  wire  [63:0] ld_do [2];
  wire  [15:0] beat  [2];

  int n_checks = 0;
  int n_pass   = 0;

  wb_mem64_resp_if bus0 ();
  wb_mem64_resp_if bus3 ();

  assign bus0.wbs_cyc_i = cyc[0];  assign bus3.wbs_cyc_i = cyc[1];
  assign bus0.wbs_stb_i = stb[0];  assign bus3.wbs_stb_i = stb[1];
  assign bus0.wbs_we_i  = we[0];   assign bus3.wbs_we_i  = we[1];
  assign bus0.wbs_cab_i = cab[0];  assign bus3.wbs_cab_i = cab[1];
  assign bus0.wbs_adr_i = adr[0];  assign bus3.wbs_adr_i = adr[1];
  assign bus0.wbs_sel_i = sel[0];  assign bus3.wbs_sel_i = sel[1];
  assign bus0.wbs_dat_i = dlo[0];  assign bus3.wbs_dat_i = dlo[1];
  assign bus0.wbs_dat64_i = dhi[0]; assign bus3.wbs_dat64_i = dhi[1];
  assign rlo[0] = bus0.wbs_dat_o;   assign rlo[1] = bus3.wbs_dat_o;
  assign rhi[0] = bus0.wbs_dat64_o; assign rhi[1] = bus3.wbs_dat64_o;
  assign ack[0] = bus0.wbs_ack_o;   assign ack[1] = bus3.wbs_ack_o;
  assign err[0] = bus0.wbs_err_o;   assign err[1] = bus3.wbs_err_o;
  assign rty[0] = bus0.wbs_rty_o;   assign rty[1] = bus3.wbs_rty_o;

  wb_mem64_resp #(.AW(10), .WAIT(0)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0),
    .ld_we_i(ld_we[0]), .ld_adr_i(ld_adr[0]), .ld_dat_i(ld_di[0]),
    .ld_dat_o(ld_do[0]), .beat_cnt_o(beat[0])
  );

  wb_mem64_resp #(.AW(10), .WAIT(3)) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus3),
    .ld_we_i(ld_we[1]), .ld_adr_i(ld_adr[1]), .ld_dat_i(ld_di[1]),
    .ld_dat_o(ld_do[1]), .beat_cnt_o(beat[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input int d, input logic [9:0] idx, input logic [63:0] val);
    ld_we[d] = 1'b1; ld_adr[d] = idx; ld_di[d] = val;
    tick();
    ld_we[d] = 1'b0;
  endtask

  task automatic peek(input int d, input logic [9:0] idx, output logic [63:0] val);
    ld_adr[d] = idx;
    #1;
    val = ld_do[d];
  endtask

  // One beat: cyc stays high afterwards; lat counts edges from the sampling
  // edge until a termination is visible (-1 on timeout).
  task automatic beat_xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                           input logic [63:0] wd, output int lat, output bit got_err);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s;
    dlo[d] = wd[31:0]; dhi[d] = wd[63:32];
    lat = 0;
    got_err = 1'b0;
    while (lat < 40) begin
      tick();
      lat++;
      if (ack[d] || err[d]) break;
    end
    if (!(ack[d] || err[d])) lat = -1;
    got_err = err[d];
    stb[d] = 1'b0; we[d] = 1'b0;
    tick();
    check("term_one_cycle", {62'd0, ack[d], err[d]}, 64'd0);
  endtask

  task automatic end_cycle(input int d);
    cyc[d] = 1'b0;
    tick();
  endtask

  int          lat;
  bit          e;
  bit          seen;
  logic [63:0] v;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; cab[d] = 0; adr[d] = 0; sel[d] = 0;
      dlo[d] = 0; dhi[d] = 0; ld_we[d] = 0; ld_adr[d] = 0; ld_di[d] = 0;
    end
    rst = 1'b1;
    tick(); tick();
    check("rst_ack",  {63'd0, ack[0]}, 64'd0);
    check("rst_err",  {63'd0, err[0]}, 64'd0);
    check("rst_rty",  {63'd0, rty[0]}, 64'd0);
    check("rst_dat",  {rhi[0], rlo[0]}, 64'd0);
    check("rst_beat", {48'd0, beat[0]}, 64'd0);
    check("rst_ack3", {63'd0, ack[1]}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: preload and WAIT=0 read.
    ld_write(0, 10'd0, {32'h300, 32'h200});
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0; sel[0] = 4'hF;
    tick();
    check("t1_ack", {63'd0, ack[0]}, 64'd1);
    check("t1_lo", {32'd0, rlo[0]}, 64'h200);
    check("t1_hi", {32'd0, rhi[0]}, 64'h300);
    stb[0] = 1'b0;
    tick();
    check("t1_beat", {48'd0, beat[0]}, 64'd1);
    end_cycle(0);
    check("t1_beat_clr", {48'd0, beat[0]}, 64'd0);

    // 2: WAIT=3 partial write.
    ld_write(1, 10'd1, 64'd0);
    beat_xfer(1, 1'b1, 32'h8, 4'b0011, {32'h11223344, 32'hAABBCCDD}, lat, e);
    end_cycle(1);
    check("t2_lat", 64'(lat), 64'd4);
    peek(1, 10'd1, v);
    check("t2_mem", v, {32'h00003344, 32'h0000CCDD});

    // 3: four-beat read burst.
    for (int i = 1; i < 4; i++)
      ld_write(0, 10'(i), {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
    cab[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat_xfer(0, 1'b0, 32'(i * 8), 4'hF, 64'd0, lat, e);
      check("t3_lat", 64'(lat), 64'd1);
      check("t3_dat", {rhi[0], rlo[0]},
            (i == 0) ? {32'h300, 32'h200} : {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)});
    end
    check("t3_beat", {48'd0, beat[0]}, 64'd4);
    cab[0] = 1'b0;
    end_cycle(0);
    check("t3_beat_clr", {48'd0, beat[0]}, 64'd0);

    // 4: drop strobe mid-WAIT on a write.
    ld_write(1, 10'd5, 64'h5555_5555_5555_5555);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h28; sel[1] = 4'hF;
    dlo[1] = 32'hFFFF_FFFF; dhi[1] = 32'hFFFF_FFFF;
    tick(); tick();
    stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack[1] || err[1]) seen = 1'b1;
    end
    check("t4_no_ack", {63'd0, seen}, 64'd0);
    peek(1, 10'd5, v);
    check("t4_mem", v, 64'h5555_5555_5555_5555);
    beat_xfer(1, 1'b0, 32'h28, 4'hF, 64'd0, lat, e);
    end_cycle(1);
    check("t4_rd_lat", 64'(lat), 64'd4);
    check("t4_rd_dat", {rhi[1], rlo[1]}, 64'h5555_5555_5555_5555);

    // 5: same-edge backdoor/bus write to index 2.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; sel[0] = 4'hF;
    dlo[0] = 32'hDEAD_BEEF; dhi[0] = 32'hCAFE_F00D;
    tick();
    check("t5_ack", {63'd0, ack[0]}, 64'd1);
    ld_we[0] = 1'b1; ld_adr[0] = 10'd2; ld_di[0] = 64'h0123_4567_89AB_CDEF;
    stb[0] = 1'b0; we[0] = 1'b0;
    tick();
    ld_we[0] = 1'b0;
    end_cycle(0);
    peek(0, 10'd2, v);
    check("t5_ld_wins", v, 64'h0123_4567_89AB_CDEF);

    // Byte enables across both lanes, then read back over the bus.
    ld_write(0, 10'd4, 64'd0);
    beat_xfer(0, 1'b1, 32'h20, 4'b1010, {32'h11223344, 32'h55667788}, lat, e);
    peek(0, 10'd4, v);
    check("sel_mem", v, {32'h11003300, 32'h55007700});
    beat_xfer(0, 1'b0, 32'h20, 4'hF, 64'd0, lat, e);
    end_cycle(0);
    check("sel_rd", {rhi[0], rlo[0]}, {32'h11003300, 32'h55007700});

    // Reset mid-transaction discards the pending write.
    ld_write(1, 10'd6, 64'h6666_6666_6666_6666);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; sel[1] = 4'hF;
    dlo[1] = 32'h0; dhi[1] = 32'h0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stb[1] = 1'b0; cyc[1] = 1'b0; we[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack[1] || err[1]) seen = 1'b1;
    end
    check("rst_mid_no_ack", {63'd0, seen}, 64'd0);
    peek(1, 10'd6, v);
    check("rst_mid_mem", v, 64'h6666_6666_6666_6666);

    // 6: out-of-range address.
    beat_xfer(0, 1'b0, 32'h8, 4'hF, 64'd0, lat, e);
    check("t6_pre", {rhi[0], rlo[0]}, {32'hB000_0001, 32'hA000_0001});
    beat_xfer(0, 1'b0, 32'h0001_0000, 4'hF, 64'd0, lat, e);
    check("t6_lat", 64'(lat), 64'd1);
`ifdef WB_MEM64_ERR_EN
    check("t6_err", {63'd0, e}, 64'd1);
    check("t6_dat_held", {rhi[0], rlo[0]}, {32'hB000_0001, 32'hA000_0001});
`else
    check("t6_err", {63'd0, e}, 64'd0);
    check("t6_alias", {rhi[0], rlo[0]}, {32'h300, 32'h200});
`endif
    check("t6_beat", {48'd0, beat[0]}, 64'd2);
    end_cycle(0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
